// File: rtl/pulse_stretcher_pkg.sv
// pulse_stretcher_pkg: shared state type and default sizing for the pulse stretcher
package pulse_stretcher_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, COOLDOWN} state_t;
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CNT_W = 8;
endpackage

// File: rtl/stretch_chan.sv
// stretch_chan: one channel stretching a trigger to a fixed high time followed by an optional low gap
module stretch_chan
  import pulse_stretcher_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic [CNT_W-1:0] stretch_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic             retrig_en,
  input  logic             drop_clr,
  output logic             signal_out,
  output logic             busy,
  output logic             drop
);
  state_t state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt, load;
  logic hit;
  assign load = stretch_len == '0 ? CNT_W'(1) : stretch_len;
  assign hit = pulse_in && (state == COOLDOWN || (state == ACTIVE && !retrig_en));
  // next state and count; a zero stretch still gives one high cycle, a zero gap skips cooldown
  always_comb begin
    nxt_state = state;
    nxt_cnt = cnt;
    case (state)
      IDLE: begin
        nxt_state = pulse_in ? ACTIVE : IDLE;
        nxt_cnt = pulse_in ? load : cnt;
      end
      ACTIVE: begin
        nxt_state = (pulse_in && retrig_en) || cnt != CNT_W'(1) ? ACTIVE : gap_len != '0 ? COOLDOWN : IDLE;
        nxt_cnt = pulse_in && retrig_en ? load : cnt == CNT_W'(1) ? gap_len : cnt - 1'b1;
      end
      COOLDOWN: begin
        nxt_state = cnt == CNT_W'(1) ? IDLE : COOLDOWN;
        nxt_cnt = cnt - 1'b1;
      end
      default: begin
        nxt_state = IDLE;
        nxt_cnt = '0;
      end
    endcase
  end
  // state, counter and outputs registered from the next state so they change together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      signal_out <= 1'b0;
      busy <= 1'b0;
      drop <= 1'b0;
    end else begin
      state <= nxt_state;
      cnt <= nxt_cnt;
      signal_out <= nxt_state == ACTIVE;
      busy <= nxt_state != IDLE;
      drop <= hit | (drop & ~drop_clr);
    end
  end
endmodule

// File: rtl/pulse_stretcher_mc.sv
// pulse_stretcher_mc: NUM_CH independent pulse stretchers sharing one configuration
module pulse_stretcher_mc
  import pulse_stretcher_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] pulse_in,
  input  logic [CNT_W-1:0]  stretch_len,
  input  logic [CNT_W-1:0]  gap_len,
  input  logic              retrig_en,
  input  logic              drop_clr,
  output logic [NUM_CH-1:0] signal_out,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] drop
);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    stretch_chan #(.CNT_W(CNT_W)) u_chan (
      .clk(clk),
      .rst(rst),
      .pulse_in(pulse_in[c]),
      .stretch_len(stretch_len),
      .gap_len(gap_len),
      .retrig_en(retrig_en),
      .drop_clr(drop_clr),
      .signal_out(signal_out[c]),
      .busy(busy[c]),
      .drop(drop[c])
    );
  end
endmodule

// File: doc/pulse_stretcher_mc.md
PULSE_STRETCHER_MC -- requirements
Module: pulse_stretcher_mc

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent channels (>=1).
REQ-002 SHALL have parameter CNT_W, default 8: width of length/gap counters.
REQ-003 SHALL have port clk, input, 1: single clock; all logic on posedge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port pulse_in, input, NUM_CH: per-channel trigger, active-high, sampled each cycle.
REQ-006 SHALL have port stretch_len, input, CNT_W: output high-time in cycles, shared by all channels, sampled on trigger.
REQ-007 SHALL have port gap_len, input, CNT_W: minimum low-time after a stretched pulse, sampled at ACTIVE exit.
REQ-008 SHALL have port retrig_en, input, 1: 1 = retrigger mode, 0 = hold mode; applies to all channels.
REQ-009 SHALL have port drop_clr, input, 1: clears all drop flags.
REQ-010 SHALL have port signal_out, output, NUM_CH: stretched pulse per channel, registered.
REQ-011 SHALL have port busy, output, NUM_CH: channel state != IDLE, registered.
REQ-012 SHALL have port drop, output, NUM_CH: sticky flag, trigger ignored on that channel.

Function
REQ-013 SHALL implement, per channel, an FSM with states IDLE, ACTIVE, COOLDOWN and a CNT_W-bit down-counter.
REQ-014 IDLE with pulse_in=1: next state ACTIVE, cnt <= max(stretch_len,1).
REQ-015 ACTIVE: signal_out=1; cnt==1 -> COOLDOWN with cnt<=gap_len if gap_len!=0, else IDLE; otherwise cnt decrements.
REQ-016 COOLDOWN: signal_out=0; cnt==1 -> IDLE; otherwise cnt decrements.
REQ-017 Latency: signal_out rises in the cycle after the pulse_in cycle; an isolated trigger gives exactly max(stretch_len,1) high cycles.
REQ-018 Retrigger mode, pulse_in=1 in ACTIVE (including cnt==1): cnt reloads to max(stretch_len,1), state stays ACTIVE, signal_out stays high without a gap.
REQ-019 Hold mode, pulse_in=1 in ACTIVE: ignored; drop[ch] set next cycle.
REQ-020 Either mode, pulse_in=1 in COOLDOWN (including final cycle): ignored; drop[ch] set.
REQ-021 A multi-cycle pulse_in level in retrigger mode SHALL hold signal_out high until max(stretch_len,1) cycles after its last high cycle.
REQ-022 drop_clr=1 clears all drop bits next cycle; a same-cycle set on a channel wins over clear.
REQ-023 stretch_len, gap_len and retrig_en changes SHALL affect only subsequent samples; no in-flight count changes.
REQ-024 Channels SHALL be fully independent; simultaneous triggers on all channels are all accepted.

Reset
REQ-025 While rst=1: all channels in IDLE, cnt=0, signal_out=0, busy=0, drop=0, asynchronously.
REQ-026 Reset asserted mid-ACTIVE or mid-COOLDOWN: signal_out drops without waiting for clk; after release the channel accepts pulse_in on the first clk edge.

Structure
REQ-027 Package pulse_stretcher_pkg SHALL hold the state enum (IDLE, ACTIVE, COOLDOWN) and default parameter constants.
REQ-028 One sub-module, stretch_chan, SHALL implement a single channel (FSM, counter, drop flag); the top generates NUM_CH instances and shares the config inputs.

Verification
REQ-029 stretch_len=5, gap_len=0, 1-cycle pulse ch0 at cycle 10 -> signal_out[0] high cycles 11-15, busy[0] high 11-15, drop=0.
REQ-030 Retrigger, stretch_len=4, pulses at cycles 10 and 12 -> signal_out high 11-16 continuously.
REQ-031 Hold, stretch_len=4, gap_len=3, pulses at 10, 12, 17 -> high 11-14, low 15-17, pulse at 12 and 17 dropped, drop[0]=1 from cycle 13.
REQ-032 stretch_len=0, pulse at 10 -> signal_out high cycle 11 only.
REQ-033 rst asserted at cycle 13 during a stretch_len=8 pulse -> signal_out=0 immediately; release, pulse at 20 -> high from 21 for 8 cycles.
REQ-034 All NUM_CH channels pulsed same cycle plus drop_clr coincident with a drop on ch1 -> all outputs stretch identically; drop[1] remains 1.
